ines_stream_writer: RTL

Consumes the raw ROM byte stream produced by the SD-card loader (one byte per `din_valid` pulse) and writes it to the NES cartridge memory. It parses the 16-byte iNES header, skips an optional 512-byte trainer, writes PRG bytes from address 0 and CHR bytes from `CHR_BASE`, and publishes the decoded cartridge configuration. A small FIFO absorbs memory back-pressure, because the SD stream cannot be stalled.

---
 rtl/ines_stream_writer_pkg.sv | 34 +++
 rtl/ines_stream_writer_byte_fifo.sv | 51 +++++
 rtl/ines_stream_writer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ines_stream_writer_pkg.sv
// Shared constants, state encoding and error codes for the iNES stream writer.
package ines_pkg;

  localparam logic [31:0] INES_MAGIC  = 32'h4E45531A;
  localparam int          HDR_LEN     = 16;
  localparam int          TRAINER_LEN = 512;
  localparam int          PRG_UNIT    = 16384;
  localparam int          CHR_UNIT    = 8192;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_TRAINER,
    ST_PRG,
    ST_CHR,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MAGIC    = 2'd1;
  localparam logic [1:0] ERR_SIZE     = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  // Expected magic byte for header index 0..3 ("NES\x1A").
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return INES_MAGIC[31:24];
      2'd1:    return INES_MAGIC[23:16];
      2'd2:    return INES_MAGIC[15:8];
      default: return INES_MAGIC[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ines_stream_writer_byte_fifo.sv
// Small byte FIFO with synchronous push/pop, occupancy count and a head
// read straight from the storage registers.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; clear empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/ines_stream_writer.sv
// Parses an iNES byte stream, skips the optional trainer and writes PRG/CHR
// bytes into cartridge memory, publishing the decoded header fields.
//
// Memory handshake: mem_we is the request (valid), mem_ack the completion
// (ready). A write completes on a clock edge where both are high; while
// mem_we is high without mem_ack, mem_addr and mem_wdata hold steady.
module ines_stream_writer
  import ines_pkg::*;
#(
  parameter int               ADDR_W     = 22,
  parameter logic [ADDR_W-1:0] CHR_BASE  = 22'h200000,
  parameter int               FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              restart,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              loading,
  output logic              done,
  output logic [1:0]        error,
  output logic [7:0]        prg_banks,
  output logic [7:0]        chr_banks,
  output logic [7:0]        mapper,
  output logic              mirroring,
  output logic              battery,
  output state_t            dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = ADDR_W + 1;

  state_t            state;
  logic [3:0]        hdr_idx;
  logic [ADDR_W-1:0] cnt;
  logic              has_trainer;

  logic [7:0]        fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  logic              pop;
  logic              push_acc;
  logic              overflow;
  logic [CW-1:0]     fill_next;
  logic              we_cont;

  logic [SW-1:0]     prg_size;
  logic [SW-1:0]     chr_size;
  logic              prg_bad;
  logic              prg_last;
  logic              chr_last;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .clear  (restart),
    .push   (push_acc),
    .din    (din),
    .pop    (pop),
    .head   (fifo_head),
    .count  (fifo_count),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // Sizes at ADDR_W+1 bits so a full-range PRG count cannot wrap.
  assign prg_size = SW'(prg_banks) * SW'(PRG_UNIT);
  assign chr_size = SW'(chr_banks) * SW'(CHR_UNIT);
  assign prg_bad  = (prg_banks == 8'd0) || (prg_size > {1'b0, CHR_BASE});
  assign prg_last = ({1'b0, cnt} == prg_size - SW'(1));
  assign chr_last = ({1'b0, cnt} == chr_size - SW'(1));

  // Pop policy, push acceptance and whether a write request continues.
  always_comb begin
    pop = 1'b0;
    case (state)
      ST_PRG, ST_CHR: pop = mem_we & mem_ack;
      default:        pop = ~fifo_empty;
    endcase
    push_acc  = din_valid & ~restart & (~fifo_full | pop);
    overflow  = din_valid & ~restart & fifo_full & ~pop;
    fill_next = fifo_count + CW'(push_acc) - CW'(pop);
    // An active request may roll onto a byte landing this edge; an idle one
    // only rises once a byte was already sitting in the FIFO.
    we_cont   = mem_we ? (fill_next != '0) : (fifo_count != CW'(pop));
  end

  assign mem_addr  = (state == ST_CHR) ? CHR_BASE + cnt : cnt;
  assign mem_wdata = mem_we ? fifo_head : 8'h00;
  assign dbg_state = state;

  // Main sequencer: header parse, trainer skip, PRG/CHR writes, terminal states.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_HDR;
      hdr_idx     <= '0;
      cnt         <= '0;
      has_trainer <= 1'b0;
      mem_we      <= 1'b0;
      loading     <= 1'b0;
      done        <= 1'b0;
      error       <= ERR_NONE;
      prg_banks   <= '0;
      chr_banks   <= '0;
      mapper      <= '0;
      mirroring   <= 1'b0;
      battery     <= 1'b0;
    end else if (restart) begin
      state       <= ST_HDR;
      hdr_idx     <= '0;
      cnt         <= '0;
      has_trainer <= 1'b0;
      mem_we      <= 1'b0;
      loading     <= 1'b0;
      done        <= 1'b0;
      error       <= ERR_NONE;
      prg_banks   <= '0;
      chr_banks   <= '0;
      mapper      <= '0;
      mirroring   <= 1'b0;
      battery     <= 1'b0;
    end else begin
      if (push_acc && state != ST_DONE && state != ST_ERR) loading <= 1'b1;
      mem_we <= 1'b0;
      case (state)
        ST_HDR: begin
          if (pop) begin
            hdr_idx <= hdr_idx + 4'd1;
            case (hdr_idx)
              4'd0, 4'd1, 4'd2, 4'd3: begin
                if (fifo_head != magic_byte(hdr_idx[1:0])) begin
                  state   <= ST_ERR;
                  error   <= ERR_MAGIC;
                  loading <= 1'b0;
                end
              end
              4'd4: prg_banks <= fifo_head;
              4'd5: chr_banks <= fifo_head;
              4'd6: begin
                mapper[3:0] <= fifo_head[7:4];
                mirroring   <= fifo_head[0];
                battery     <= fifo_head[1];
                has_trainer <= fifo_head[2];
              end
              4'd7: mapper[7:4] <= fifo_head[7:4];
              4'(HDR_LEN - 1): begin
                cnt <= '0;
                if (prg_bad) begin
                  state   <= ST_ERR;
                  error   <= ERR_SIZE;
                  loading <= 1'b0;
                end else if (has_trainer) begin
                  state <= ST_TRAINER;
                end else begin
                  state  <= ST_PRG;
                  mem_we <= we_cont;
                end
              end
              default: ;
            endcase
          end
        end
        ST_TRAINER: begin
          if (pop) begin
            if (cnt == ADDR_W'(TRAINER_LEN - 1)) begin
              state  <= ST_PRG;
              cnt    <= '0;
              mem_we <= we_cont;
            end else begin
              cnt <= cnt + ADDR_W'(1);
            end
          end
        end
        ST_PRG: begin
          if (pop && prg_last) begin
            cnt <= '0;
            if (chr_banks != 8'd0) begin
              state  <= ST_CHR;
              mem_we <= we_cont;
            end else begin
              state   <= ST_DONE;
              done    <= 1'b1;
              loading <= 1'b0;
            end
          end else begin
            if (pop) cnt <= cnt + ADDR_W'(1);
            mem_we <= we_cont;
          end
        end
        ST_CHR: begin
          if (pop && chr_last) begin
            cnt     <= '0;
            state   <= ST_DONE;
            done    <= 1'b1;
            loading <= 1'b0;
          end else begin
            if (pop) cnt <= cnt + ADDR_W'(1);
            mem_we <= we_cont;
          end
        end
        default: ;
      endcase
      if (overflow) begin
        state   <= ST_ERR;
        error   <= ERR_OVERFLOW;
        loading <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end

endmodule
